// File: rtl/nano_intc_pkg.sv
// nano_intc_pkg: register offsets, ACTIVE field layout and channel limit for nano_intc_n
package nano_intc_pkg;
  localparam int MAX_CH = 8;
  localparam logic [7:0] OFF_ENABLE   = 8'd0;
  localparam logic [7:0] OFF_PENDING  = 8'd1;
  localparam logic [7:0] OFF_POLARITY = 8'd2;
  localparam logic [7:0] OFF_ACTIVE   = 8'd3;
  localparam logic [7:0] OFF_CTRL     = 8'd4;
  localparam int ACT_INS_BIT = 7;
  localparam int ACT_ID_W    = 3;
endpackage

// File: rtl/nano_edge_det.sv
// nano_edge_det: per-channel sampler, history flop and polarity-selected edge strobe
// NANO_INTC_SYNC_EN adds a second synchronizer flop for asynchronous pins.
module nano_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic pol,
  output logic edge_p
);
  logic s1_d, s1_q, prev_q;
`ifdef NANO_INTC_SYNC_EN
  logic s0_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) s0_q <= 1'b0;
    else     s0_q <= x;
  assign s1_d = s0_q;
`else
  assign s1_d = x;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      prev_q <= s1_q;
    end
  assign edge_p = pol ? (prev_q & ~s1_q) : (~prev_q & s1_q);
endmodule

// File: rtl/nano_intc_n.sv
// nano_intc_n: N-channel io-mapped interrupt controller with fixed priority and in-service tracking
// Build option: NANO_INTC_SYNC_EN (2-flop pin synchronizer, +1 clk latency).
module nano_intc_n
  import nano_intc_pkg::*;
#(
  parameter int         N_CH     = 3,
  parameter logic [7:0] BASE_ADD = 8'h00,
  parameter logic [7:0] POL_RST  = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      add,
  input  logic [7:0]      data_i,
  output logic [7:0]      data_o,
  input  logic            we,
  input  logic [N_CH-1:0] eint,
  input  logic            irq_ack,
  output logic            irq,
  output logic [2:0]      irq_id
);
  logic [N_CH-1:0] en_q, en_d, pend_q, pend_d, pol_q, pol_d, edges, mask, ack_clr, din;
  logic gie_q, gie_d, ins_q, ins_d, ack;
  logic [2:0] id_q, id_d, pid;
  logic [7:0] off, act;
  logic wr_en, wr_pend, wr_pol, wr_act, wr_ctrl;
  logic unused_data_bits;
  assign unused_data_bits = ^data_i;
  for (genvar i = 0; i < N_CH; i++) begin : g_ed
    nano_edge_det u_ed (.clk(clk), .rst(rst), .x(eint[i]), .pol(pol_q[i]), .edge_p(edges[i]));
  end
  assign mask = pend_q & en_q;
  always_comb begin
    pid = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (mask[i]) pid = 3'(i);
  end
  assign irq     = gie_q & ~ins_q & |mask;
  assign irq_id  = irq ? pid : 3'd0;
  assign ack     = irq_ack & irq;
  assign ack_clr = ack ? (N_CH'(1) << pid) : '0;
  // Wrapping subtraction pushes addresses below BASE_ADD out of the decoded window.
  assign off     = add - BASE_ADD;
  assign din     = data_i[N_CH-1:0];
  assign wr_en   = we && off == OFF_ENABLE;
  assign wr_pend = we && off == OFF_PENDING;
  assign wr_pol  = we && off == OFF_POLARITY;
  assign wr_act  = we && off == OFF_ACTIVE;
  assign wr_ctrl = we && off == OFF_CTRL;
  always_comb begin
    en_d   = wr_en ? din : en_q;
    pol_d  = wr_pol ? din : pol_q;
    gie_d  = wr_ctrl ? data_i[0] : gie_q;
    pend_d = (pend_q & ~(wr_pend ? din : '0) & ~ack_clr) | edges;
    ins_d  = ack ? 1'b1 : wr_act ? 1'b0 : ins_q;
    id_d   = ack ? pid : id_q;
  end
  always_comb begin
    act = '0;
    act[ACT_INS_BIT] = ins_q;
    act[ACT_ID_W-1:0] = id_q;
    data_o = off == OFF_ENABLE   ? 8'(en_q)   :
             off == OFF_PENDING  ? 8'(pend_q) :
             off == OFF_POLARITY ? 8'(pol_q)  :
             off == OFF_ACTIVE   ? act        :
             off == OFF_CTRL     ? {7'b0, gie_q} : 8'h00;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en_q   <= '0;
      pend_q <= '0;
      pol_q  <= POL_RST[N_CH-1:0];
      gie_q  <= 1'b0;
      ins_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      en_q   <= en_d;
      pend_q <= pend_d;
      pol_q  <= pol_d;
      gie_q  <= gie_d;
      ins_q  <= ins_d;
      id_q   <= id_d;
    end
endmodule

// File: tb/tb_nano_intc_n.sv
// tb_nano_intc_n: register table, directed corner sequences and randomized run against a behavioural model
module tb_nano_intc_n;
`ifdef NANO_INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, we = 0, irq_ack = 0;
  logic [7:0] add = 0, data_i = 0;
  logic [2:0] eint = 0;
  logic [7:0] data_o;
  logic irq;
  logic [2:0] irq_id;
  int pass_cnt = 0, tot_cnt = 0;

  nano_intc_n #(.N_CH(3), .BASE_ADD(8'h00), .POL_RST(8'h00)) dut (
    .clk(clk), .rst(rst), .add(add), .data_i(data_i), .data_o(data_o), .we(we),
    .eint(eint), .irq_ack(irq_ack), .irq(irq), .irq_id(irq_id));

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl[12];

  logic [2:0] m_en, m_pend, m_pol, m_id;
  logic m_gie, m_ins;
  logic [2:0] smp[3];

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(string name, logic [7:0] a, logic [7:0] e);
    add = a;
    #1;
    chk(name, data_o, e);
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    add = a;
    data_i = d;
    we = 1;
    tick();
    we = 0;
  endtask

  function automatic int m_top();
    for (int i = 0; i < 3; i++) if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic logic m_irq();
    return m_gie && !m_ins && m_top() >= 0;
  endfunction

  function automatic logic [7:0] m_read(logic [7:0] a);
    case (a)
      8'd0:    return {5'b0, m_en};
      8'd1:    return {5'b0, m_pend};
      8'd2:    return {5'b0, m_pol};
      8'd3:    return {m_ins, 4'b0, m_id};
      8'd4:    return {7'b0, m_gie};
      default: return 8'h00;
    endcase
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int p;
    logic took;
    logic [2:0] fresh, cur, prv;
    p = m_top();
    took = irq_ack && m_irq();
    cur = smp[LAT-1];
    prv = smp[LAT];
    for (int i = 0; i < 3; i++)
      fresh[i] = m_pol[i] ? (prv[i] && !cur[i]) : (!prv[i] && cur[i]);
    if (we && add == 8'd1) m_pend = m_pend & ~data_i[2:0];
    if (took) m_pend[p] = 1'b0;
    m_pend = m_pend | fresh;
    if (we && add == 8'd0) m_en = data_i[2:0];
    if (we && add == 8'd2) m_pol = data_i[2:0];
    if (we && add == 8'd4) m_gie = data_i[0];
    if (took) begin
      m_ins = 1'b1;
      m_id = 3'(p);
    end else if (we && add == 8'd3) m_ins = 1'b0;
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = eint;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 8'hff, 8'h00, 8'h07};
    tbl[1]  = '{1'b1, 8'h04, 8'hff, 8'h04, 8'h01};
    tbl[2]  = '{1'b1, 8'h02, 8'h05, 8'h02, 8'h05};
    tbl[3]  = '{1'b1, 8'h02, 8'h00, 8'h02, 8'h00};
    tbl[4]  = '{1'b1, 8'h01, 8'hff, 8'h01, 8'h00};
    tbl[5]  = '{1'b1, 8'h03, 8'h55, 8'h03, 8'h00};
    tbl[6]  = '{1'b1, 8'h05, 8'hff, 8'h05, 8'h00};
    tbl[7]  = '{1'b1, 8'h00, 8'h03, 8'h00, 8'h03};
    tbl[8]  = '{1'b1, 8'h04, 8'h00, 8'h04, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 8'h07, 8'h00};
    tbl[10] = '{1'b1, 8'h04, 8'h01, 8'h04, 8'h01};
    tbl[11] = '{1'b1, 8'h00, 8'h07, 8'h00, 8'h07};

    repeat (2) tick();
    for (int r = 0; r < 5; r++) rd($sformatf("rst_reg%0d", r), 8'(r), 8'h00);
    chk("rst_irq", irq, 0);
    rst = 0;
    tick();

    for (int i = 0; i < 12; i++) begin
      add = tbl[i].wa;
      data_i = tbl[i].wd;
      we = tbl[i].we;
      tick();
      we = 0;
      rd($sformatf("tbl%0d", i), tbl[i].ra, tbl[i].rd);
      chk($sformatf("tbl%0d_irq", i), irq, 0);
    end

    // Two rising edges, priority, acknowledge, EOI and second acknowledge.
    eint = 3'b100;
    tick();
    eint = 3'b101;
    repeat (3) tick();
    rd("a_pend", 8'd1, 8'h05);
    chk("a_irq", irq, 1);
    chk("a_id", irq_id, 0);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    rd("a_pend_ack", 8'd1, 8'h04);
    rd("a_active", 8'd3, 8'h80);
    chk("a_irq_ins", irq, 0);
    wr(8'd3, 8'h00);
    chk("eoi_irq", irq, 1);
    chk("eoi_id", irq_id, 2);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    rd("eoi_active", 8'd3, 8'h82);
    rd("eoi_pend", 8'd1, 8'h00);
    wr(8'd3, 8'h00);
    chk("eoi2_irq", irq, 0);

    // Falling polarity on channel 1 and its latency.
    wr(8'd2, 8'h02);
    eint = 3'b111;
    repeat (LAT + 2) tick();
    rd("pol_rise_ignored", 8'd1, 8'h00);
    eint = 3'b101;
    tick();
    rd("pol_k", 8'd1, 8'h00);
    for (int j = 1; j <= LAT; j++) begin
      tick();
      rd($sformatf("pol_k%0d", j), 8'd1, j == LAT ? 8'h02 : 8'h00);
    end
    chk("pol_irq", irq, 1);
    chk("pol_id", irq_id, 1);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    wr(8'd3, 8'h00);

    // W1C racing a fresh edge on channel 0.
    wr(8'd2, 8'h00);
    eint = 3'b100;
    repeat (LAT + 2) tick();
    eint = 3'b101;
    repeat (LAT + 2) tick();
    rd("w1c_pre", 8'd1, 8'h01);
    eint = 3'b100;
    repeat (LAT + 2) tick();
    eint = 3'b101;
    tick();
    repeat (LAT - 1) tick();
    wr(8'd1, 8'h01);
    rd("w1c_vs_set", 8'd1, 8'h01);
    wr(8'd1, 8'h01);
    rd("w1c_alone", 8'd1, 8'h00);

    // Masked channel stays pending until enabled.
    wr(8'd0, 8'h00);
    wr(8'd1, 8'hff);
    eint = 3'b111;
    repeat (LAT + 2) tick();
    rd("mask_pend", 8'd1, 8'h02);
    chk("mask_irq", irq, 0);
    wr(8'd0, 8'h02);
    chk("unmask_irq", irq, 1);
    chk("unmask_id", irq_id, 1);
    rd("unmapped5", 8'd5, 8'h00);

    // Asynchronous reset mid-run with PENDING=5.
    eint = 3'b000;
    repeat (LAT + 2) tick();
    wr(8'd1, 8'hff);
    eint = 3'b101;
    repeat (LAT + 2) tick();
    wr(8'd0, 8'h07);
    rd("prerst_pend", 8'd1, 8'h05);
    chk("prerst_irq", irq, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_irq", irq, 0);
    chk("arst_id", irq_id, 0);
    for (int r = 0; r < 5; r++) rd($sformatf("arst_reg%0d", r), 8'(r), 8'h00);
    eint = 3'b000;
    repeat (2) tick();
    rst = 0;
    m_en = 0; m_pend = 0; m_pol = 0; m_id = 0; m_gie = 0; m_ins = 0;
    for (int i = 0; i < 3; i++) smp[i] = 3'b000;

    for (int n = 0; n < 600; n++) begin
      add = 8'($urandom_range(0, 6));
      data_i = 8'($urandom);
      we = ($urandom_range(0, 2) == 0);
      irq_ack = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) eint[b] = ~eint[b];
      model_step();
      tick();
      chk($sformatf("rnd%0d_irq", n), irq, m_irq());
      chk($sformatf("rnd%0d_id", n), irq_id, m_irq() ? 3'(m_top()) : 3'd0);
      chk($sformatf("rnd%0d_rd%0d", n, add), data_o, m_read(add));
      we = 0;
      irq_ack = 0;
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
